// File: rtl/axi4_burst_master_if.sv
// axi4_burst_master_if: AXI4 bus bundle between the burst master and a slave.
//   master modport: drives AW/W/AR channels and B/R ready, samples the rest.
//   slave  modport: the mirror image.
// Widths are parameters so the bundle matches the master's DATA/ADDR/ID widths.
interface axi4_burst_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_burst_master.sv
// axi4_burst_master: single-outstanding AXI4 INCR burst initiator.
//   clk, rst                   clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/len   one command per burst (len = beats-1)
//   wr_valid/ready/data/strb   write beat stream, passed through to W
//   rd_valid/ready/data/last   read beat stream, passed through from R
//   done/done_resp/done_err    registered completion pulse with status
//   m_axi                      AXI4 master bus
// Beats are counted from cmd_len; slave rlast and response IDs are only
// checked and folded into done_err, never used to steer the FSM.
module axi4_burst_master #(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   ADDR_WIDTH = 8,
    parameter int                   ID_WIDTH   = 8,
    parameter logic [ID_WIDTH-1:0]  TXN_ID     = '0
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,

    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,

    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,

    output logic                    done,
    output logic [1:0]              done_resp,
    output logic                    done_err,

    axi4_burst_master_if.master     m_axi
);
    localparam logic [2:0] AXSIZE = 3'($clog2(DATA_WIDTH/8));

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            resp_q, resp_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic [1:0]            done_resp_q, done_resp_d;
    logic                  done_err_q, done_err_d;

    logic                  last_beat;
    logic [1:0]            rresp_max;
    logic                  r_bad;

    assign last_beat = (cnt_q == 8'd0);
    assign rresp_max = (m_axi.rresp > resp_q) ? m_axi.rresp : resp_q;
    // A beat is malformed if its ID is foreign or slave framing disagrees with our count.
    assign r_bad     = (m_axi.rid != TXN_ID) || (m_axi.rlast != last_beat);

    // Address-phase fields come straight from the latched command, so they
    // are stable for as long as awvalid/arvalid is held.
    assign m_axi.awid    = TXN_ID;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = len_q;
    assign m_axi.awsize  = AXSIZE;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'h0;
    assign m_axi.awprot  = 3'h0;
    assign m_axi.arid    = TXN_ID;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arsize  = AXSIZE;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'h0;
    assign m_axi.arprot  = 3'h0;

    assign m_axi.wdata = wr_data;
    assign m_axi.wstrb = wr_strb;
    assign m_axi.wlast = last_beat;
    assign rd_data     = m_axi.rdata;
    assign rd_last     = last_beat;

    assign done      = done_q;
    assign done_resp = done_resp_q;
    assign done_err  = done_err_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        addr_d        = addr_q;
        resp_d        = resp_q;
        err_d         = err_q;
        done_d        = 1'b0;
        done_resp_d   = done_resp_q;
        done_err_d    = done_err_q;
        cmd_ready     = 1'b0;
        wr_ready      = 1'b0;
        rd_valid      = 1'b0;
        m_axi.awvalid = 1'b0;
        m_axi.wvalid  = 1'b0;
        m_axi.bready  = 1'b0;
        m_axi.arvalid = 1'b0;
        m_axi.rready  = 1'b0;

        // Handshake outputs are held low while rst is asserted so nothing
        // leaks out of a state that is about to be abandoned.
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        addr_d  = cmd_addr;
                        len_d   = cmd_len;
                        cnt_d   = cmd_len;
                        resp_d  = 2'b00;
                        err_d   = 1'b0;
                        state_d = cmd_write ? AW : AR;
                    end
                end
                AW: begin
                    m_axi.awvalid = 1'b1;
                    if (m_axi.awready) state_d = W;
                end
                W: begin
                    m_axi.wvalid = wr_valid;
                    wr_ready     = m_axi.wready;
                    if (wr_valid && m_axi.wready) begin
                        if (last_beat) state_d = B;
                        else           cnt_d   = cnt_q - 8'd1;
                    end
                end
                B: begin
                    m_axi.bready = 1'b1;
                    if (m_axi.bvalid) begin
                        done_d      = 1'b1;
                        done_resp_d = m_axi.bresp;
                        done_err_d  = (m_axi.bid != TXN_ID);
                        state_d     = IDLE;
                    end
                end
                AR: begin
                    m_axi.arvalid = 1'b1;
                    if (m_axi.arready) state_d = R;
                end
                R: begin
                    rd_valid     = m_axi.rvalid;
                    m_axi.rready = rd_ready;
                    if (m_axi.rvalid && rd_ready) begin
                        resp_d = rresp_max;
                        err_d  = err_q | r_bad;
                        if (last_beat) begin
                            done_d      = 1'b1;
                            done_resp_d = rresp_max;
                            done_err_d  = err_q | r_bad;
                            state_d     = IDLE;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            len_q       <= 8'd0;
            addr_q      <= '0;
            resp_q      <= 2'b00;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            done_resp_q <= 2'b00;
            done_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
            done_err_q  <= done_err_d;
        end
    end
endmodule

// File: tb/tb_axi4_burst_master.sv
// tb_axi4_burst_master: scoreboard bench with a small AXI4 RAM slave model.
module tb_axi4_burst_master;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int IW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0, cmd_len = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;
    logic        rd_valid, rd_ready = 1'b0, rd_last;
    logic [31:0] rd_data;
    logic        done, done_err;
    logic [1:0]  done_resp;

    always #5 clk = ~clk;

    axi4_burst_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

    axi4_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .TXN_ID(8'h00)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp), .done_err(done_err),
        .m_axi(axi)
    );

    int n_chk = 0;
    int n_err = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Slave behaviour knobs
    logic       cfg_stall = 1'b0;
    logic       cfg_gap = 1'b0;
    logic [7:0] cfg_bid = 8'h00;
    int         cfg_rresp_beat = -1;
    logic [1:0] cfg_rresp_val = 2'b00;
    int         cfg_rlast_beat = -1;

    // Scoreboard queues
    typedef struct { logic [7:0] a; logic [7:0] l; } ax_t;
    typedef struct { logic [31:0] d; logic [3:0] s; logic l; } wb_t;
    typedef struct { logic [31:0] d; logic l; } rb_t;
    typedef struct { logic [1:0] resp; logic err; } dn_t;
    ax_t exp_aw[$], exp_ar[$];
    wb_t exp_w[$];
    rb_t exp_r[$];
    dn_t exp_d[$];
    ax_t e_ax;
    wb_t e_w;
    rb_t e_r;
    dn_t e_d;

    logic [31:0] mmem [0:63];   // expected memory contents
    logic [31:0] wd [0:255];
    logic [3:0]  ws [0:255];

    // ---------------- monitor ----------------
    logic        p_aw_stall = 0, p_ar_stall = 0, p_rd_stall = 0;
    logic [7:0]  p_addr, p_len;
    logic [31:0] p_rdata;
    localparam logic [20:0] AX_FIXED = {8'h00, 3'd2, 2'b01, 1'b0, 4'h0, 3'h0};

    always @(negedge clk) begin
        if (!rst) begin
            if (p_aw_stall) check("aw_stable", {axi.awvalid, axi.awaddr, axi.awlen}, {1'b1, p_addr, p_len});
            if (p_ar_stall) check("ar_stable", {axi.arvalid, axi.araddr, axi.arlen}, {1'b1, p_addr, p_len});
            if (p_rd_stall) check("rd_stable", {rd_valid, rd_data}, {1'b1, p_rdata});
            if (axi.awvalid && axi.awready) begin
                if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
                else begin
                    e_ax = exp_aw.pop_front();
                    check("aw_addr_len", {axi.awaddr, axi.awlen}, {e_ax.a, e_ax.l});
                    check("aw_fixed", {axi.awid, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot}, AX_FIXED);
                end
            end
            if (axi.arvalid && axi.arready) begin
                if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
                else begin
                    e_ax = exp_ar.pop_front();
                    check("ar_addr_len", {axi.araddr, axi.arlen}, {e_ax.a, e_ax.l});
                    check("ar_fixed", {axi.arid, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot}, AX_FIXED);
                end
            end
            if (axi.wvalid && axi.wready) begin
                if (exp_w.size() == 0) check("w_unexpected", 1, 0);
                else begin
                    e_w = exp_w.pop_front();
                    check("w_beat", {axi.wdata, axi.wstrb, axi.wlast}, {e_w.d, e_w.s, e_w.l});
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_r.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    e_r = exp_r.pop_front();
                    check("rd_beat", {rd_data, rd_last}, {e_r.d, e_r.l});
                end
            end
            if (done) begin
                if (exp_d.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    e_d = exp_d.pop_front();
                    check("done_status", {done_resp, done_err}, {e_d.resp, e_d.err});
                end
            end
            p_aw_stall = axi.awvalid && !axi.awready;
            p_ar_stall = axi.arvalid && !axi.arready;
            p_rd_stall = rd_valid && !rd_ready;
            p_addr     = axi.awvalid ? axi.awaddr : axi.araddr;
            p_len      = axi.awvalid ? axi.awlen : axi.arlen;
            p_rdata    = rd_data;
        end else begin
            p_aw_stall = 0; p_ar_stall = 0; p_rd_stall = 0;
        end
    end

    // ---------------- AXI4 RAM slave ----------------
    logic [31:0] smem [0:63];
    logic [7:0]  s_waddr, s_raddr, s_rlen;
    int          s_rbeat;
    logic        s_ract;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, s_rst;
    logic [7:0]  c_awaddr, c_araddr, c_arlen;
    logic [31:0] c_wdata;
    logic [3:0]  c_wstrb;
    logic        c_wlast;

    initial begin
        for (int i = 0; i < 64; i++) smem[i] = 32'h0;
        axi.awready = 0; axi.wready = 0; axi.arready = 0;
        axi.bvalid = 0; axi.bid = 0; axi.bresp = 0;
        axi.rvalid = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0;
        s_ract = 0; s_rbeat = 0; s_waddr = 0; s_raddr = 0; s_rlen = 0;
        forever begin
            @(negedge clk);
            s_rst = rst;
            aw_hs = axi.awvalid && axi.awready; c_awaddr = axi.awaddr;
            w_hs  = axi.wvalid && axi.wready;   c_wdata = axi.wdata; c_wstrb = axi.wstrb; c_wlast = axi.wlast;
            b_hs  = axi.bvalid && axi.bready;
            ar_hs = axi.arvalid && axi.arready; c_araddr = axi.araddr; c_arlen = axi.arlen;
            r_hs  = axi.rvalid && axi.rready;
            @(posedge clk); #1;
            if (s_rst) begin
                axi.bvalid = 0; axi.rvalid = 0; s_ract = 0;
            end else begin
                if (aw_hs) s_waddr = c_awaddr;
                if (b_hs) axi.bvalid = 0;
                if (w_hs) begin
                    for (int b = 0; b < 4; b++)
                        if (c_wstrb[b]) smem[s_waddr[7:2]][8*b +: 8] = c_wdata[8*b +: 8];
                    s_waddr = s_waddr + 8'd4;
                    if (c_wlast) begin axi.bvalid = 1; axi.bid = cfg_bid; axi.bresp = 2'b00; end
                end
                if (ar_hs) begin s_raddr = c_araddr; s_rlen = c_arlen; s_rbeat = 0; s_ract = 1; end
                if (r_hs) begin
                    s_rbeat++;
                    s_raddr = s_raddr + 8'd4;
                    if (s_rbeat > int'(s_rlen)) s_ract = 0;
                end
                if (r_hs || !axi.rvalid) begin
                    axi.rvalid = s_ract && (!cfg_stall || $urandom_range(0, 2) != 0);
                    axi.rdata  = smem[s_raddr[7:2]];
                    axi.rid    = 8'h00;
                    axi.rresp  = (s_rbeat == cfg_rresp_beat) ? cfg_rresp_val : 2'b00;
                    axi.rlast  = (s_rbeat == int'(s_rlen)) || (s_rbeat == cfg_rlast_beat);
                end
            end
            axi.awready = !cfg_stall || ($urandom_range(0, 1) == 1);
            axi.wready  = !cfg_stall || ($urandom_range(0, 1) == 1);
            axi.arready = !cfg_stall || ($urandom_range(0, 1) == 1);
        end
    end

    // Read-stream consumer
    initial forever begin
        @(posedge clk); #1;
        rd_ready = !cfg_gap || ($urandom_range(0, 2) != 0);
    end

    // ---------------- stimulus ----------------
    task automatic issue_cmd(input logic wr, input logic [7:0] a, input logic [7:0] l);
        int t = 0;
        cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        do begin @(negedge clk); t++; end while (!cmd_ready && t < 50);
        if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic feed_beat(input logic [31:0] d, input logic [3:0] s);
        int t = 0;
        if (cfg_gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        wr_valid = 1'b1; wr_data = d; wr_strb = s;
        do begin @(negedge clk); t++; end while (!wr_ready && t < 100);
        if (!wr_ready) check("wr_ready_timeout", 0, 1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        do begin @(negedge clk); t++; end while (!done && t < 300);
        if (!done) check("done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic model_write(input logic [7:0] a, input int i);
        logic [5:0] idx;
        idx = 6'(a[7:2] + 6'(i));
        for (int b = 0; b < 4; b++)
            if (ws[i][b]) mmem[idx][8*b +: 8] = wd[i][8*b +: 8];
    endtask

    task automatic write_burst(input logic [7:0] a, input logic [7:0] l,
                               input logic [1:0] resp, input logic err);
        exp_aw.push_back('{a: a, l: l});
        for (int i = 0; i <= int'(l); i++) begin
            exp_w.push_back('{d: wd[i], s: ws[i], l: (i == int'(l))});
            model_write(a, i);
        end
        exp_d.push_back('{resp: resp, err: err});
        issue_cmd(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) feed_beat(wd[i], ws[i]);
        wait_done();
    endtask

    task automatic push_read(input logic [7:0] a, input logic [7:0] l,
                             input logic [1:0] resp, input logic err);
        exp_ar.push_back('{a: a, l: l});
        for (int i = 0; i <= int'(l); i++)
            exp_r.push_back('{d: mmem[6'(a[7:2] + 6'(i))], l: (i == int'(l))});
        exp_d.push_back('{resp: resp, err: err});
    endtask

    task automatic read_burst(input logic [7:0] a, input logic [7:0] l,
                              input logic [1:0] resp, input logic err);
        push_read(a, l, resp, err);
        issue_cmd(1'b0, a, l);
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 64; i++) mmem[i] = 32'h0;

        // Reset state while rst is held
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("reset_outputs",
              {cmd_ready, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready,
               wr_ready, rd_valid, done, done_resp, done_err}, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", cmd_ready, 1);
        @(posedge clk); #1;

        // Directed write/read of 0xA0..0xA3
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
        write_burst(8'h10, 8'd3, 2'b00, 1'b0);
        read_burst(8'h10, 8'd3, 2'b00, 1'b0);

        // rresp=2 on beat 1
        cfg_rresp_beat = 1; cfg_rresp_val = 2'b10;
        read_burst(8'h10, 8'd3, 2'b10, 1'b0);
        cfg_rresp_beat = -1;

        // Early rlast on beat 2: still four beats, error flagged
        cfg_rlast_beat = 2;
        read_burst(8'h10, 8'd3, 2'b00, 1'b1);
        cfg_rlast_beat = -1;

        // Foreign bid
        cfg_bid = 8'h5A;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + i; ws[i] = 4'hF; end
        write_burst(8'h20, 8'd3, 2'b00, 1'b1);
        cfg_bid = 8'h00;

        // Partial strobe: 0x11223344 strb 0101 over 0xA0 -> 0x00220044
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        write_burst(8'h10, 8'd0, 2'b00, 1'b0);
        check("strb_model", mmem[4], 32'h00220044);
        read_burst(8'h10, 8'd0, 2'b00, 1'b0);

        // Random stalls and gaps
        cfg_stall = 1'b1; cfg_gap = 1'b1;
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
        write_burst(8'h40, 8'd7, 2'b00, 1'b0);
        read_burst(8'h40, 8'd7, 2'b00, 1'b0);
        wd[0] = 32'hCAFE0001; ws[0] = 4'hF;
        write_burst(8'h60, 8'd0, 2'b00, 1'b0);
        read_burst(8'h60, 8'd0, 2'b00, 1'b0);
        cfg_stall = 1'b0; cfg_gap = 1'b0;

        // Reset in the middle of a write after 2 of 4 beats
        for (int i = 0; i < 2; i++) begin wd[i] = 32'hD0 + i; ws[i] = 4'hF; end
        exp_aw.push_back('{a: 8'h80, l: 8'd3});
        for (int i = 0; i < 2; i++) begin
            exp_w.push_back('{d: wd[i], s: ws[i], l: 1'b0});
            model_write(8'h80, i);
        end
        issue_cmd(1'b1, 8'h80, 8'd3);
        feed_beat(wd[0], ws[0]);
        feed_beat(wd[1], ws[1]);
        rst = 1'b1;
        @(negedge clk);
        check("in_reset_outputs",
              {cmd_ready, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, wr_ready, rd_valid}, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("after_mid_rst",
              {cmd_ready, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, wr_ready, rd_valid, done},
              {1'b1, 8'h00});
        repeat (3) @(negedge clk);
        check("no_done_after_rst", done, 0);
        @(posedge clk); #1;
        wd[0] = 32'hE0; ws[0] = 4'hF;
        write_burst(8'h90, 8'd0, 2'b00, 1'b0);
        read_burst(8'h80, 8'd1, 2'b00, 1'b0);

        // Back-to-back reads with cmd_valid held
        push_read(8'h10, 8'd1, 2'b00, 1'b0);
        push_read(8'h20, 8'd0, 2'b00, 1'b0);
        issue_cmd(1'b0, 8'h10, 8'd1);
        cmd_write = 1'b0; cmd_addr = 8'h20; cmd_len = 8'd0; cmd_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!done && t < 100);
        check("b2b_done_seen", done, 1);
        check("b2b_ready_in_done", cmd_ready, 1);
        @(posedge clk); #1; cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b_arvalid_next", axi.arvalid, 1);
        @(posedge clk); #1;
        wait_done();

        repeat (3) @(posedge clk);
        #1;
        check("queues_drained",
              exp_aw.size() + exp_ar.size() + exp_w.size() + exp_r.size() + exp_d.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
